// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file and its debug dump sequencer.
package regfile_pkg;

   // Dump sequencer states
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StSend = 2'd1,
      StDone = 2'd2
   } dump_state_e;

   localparam int unsigned MaxNumRd = 4;

   function automatic int unsigned depth_of(input int unsigned addr_w);
      return 32'd1 << addr_w;
   endfunction

endpackage

// File: rtl/regfile_dbg_dump.sv
// Debug dump sequencer: walks every register index and streams it over a valid/ready link.
// Requests one capture address per cycle; the parent returns the forwarded register value.
module regfile_dbg_dump
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              ready,
   output logic [ADDR_W-1:0] cap_addr,
   input  logic [DATA_W-1:0] cap_data,
   output logic              valid,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data
);

   localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};

   dump_state_e       state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      data_d   = data_q;
      cap_addr = addr_q + 1'b1;
      valid    = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         StIdle: begin
            cap_addr = '0;
            if (start) begin
               state_d = StSend;
               addr_d  = '0;
               data_d  = cap_data;
            end
         end
         StSend: begin
            valid = 1'b1;
            busy  = 1'b1;
            // Next register is captured on the same edge that retires the current beat
            if (ready) begin
               if (addr_q == LastAddr) begin
                  state_d = StDone;
               end else begin
                  addr_d = cap_addr;
                  data_d = cap_data;
               end
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign addr = addr_q;
   assign data = data_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with a debug dump sequencer.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to read ports and dump captures.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     dbg_start,
   input  logic                     dbg_ready,
   output logic                     dbg_valid,
   output logic [ADDR_W-1:0]        dbg_addr,
   output logic [DATA_W-1:0]        dbg_data,
   output logic                     dbg_busy,
   output logic                     dbg_done
);

   localparam int unsigned DEPTH   = depth_of(ADDR_W);
   localparam bit          HasZero = (ZERO_REG != 0);

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic              wr_ok;
   logic [ADDR_W-1:0] cap_addr;
   logic [DATA_W-1:0] cap_data;

   assign wr_ok = wr_en && !(HasZero && (wr_addr == '0));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_ok) begin
         regs_q[wr_addr] <= wr_data;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] q;

      assign a = rd_addr[p*ADDR_W +: ADDR_W];

      always_comb begin
         q = regs_q[a];
         if (HasZero && (a == '0)) begin
            q = '0;
`ifdef REGFILE_BYPASS_EN
         end else if (wr_ok && (wr_addr == a)) begin
            q = wr_data;
`endif
         end
      end

      assign rd_data[p*DATA_W +: DATA_W] = q;
   end

   // Dump captures follow exactly the same zero-reg and forwarding rules as the read ports
   always_comb begin
      cap_data = regs_q[cap_addr];
      if (HasZero && (cap_addr == '0)) begin
         cap_data = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (wr_ok && (wr_addr == cap_addr)) begin
         cap_data = wr_data;
`endif
      end
   end

   regfile_dbg_dump #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_dump (
      .clk      (clk),
      .rst      (rst),
      .start    (dbg_start),
      .ready    (dbg_ready),
      .cap_addr (cap_addr),
      .cap_data (cap_data),
      .valid    (dbg_valid),
      .busy     (dbg_busy),
      .done     (dbg_done),
      .addr     (dbg_addr),
      .data     (dbg_data)
   );

endmodule
